muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit directly downstream of the general-purpose register file.
- Consumes the two register read values (a = rs, b = rt) and holds results in architectural HI/LO registers.
- Supports MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes; HI/LO are read by MFHI/MFLO through the writeback mux.
- The control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  rs operand: multiplicand or dividend.
- b  input  WIDTH  rt operand: multiplier or divisor.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- start  input  1  launch op on a/b; sampled only when idle.
- mthi  input  1  write wdata into HI.
- mtlo  input  1  write wdata into LO.
- wdata  input  WIDTH  MTHI/MTLO data (the rs value).
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO have just been updated by an op.

Behaviour:
- Reset (async, reset_n = 0): state IDLE; hi = 0, lo = 0, busy = 0, done = 0; iteration counter and operand latches cleared.
- Reset mid-operation aborts the op; HI/LO go to 0. No partial result is ever written.
- FSM states: IDLE, RUN, FIX.
- IDLE -> RUN: on a clock edge k with start = 1, the block latches a, b and op.
  - For signed ops it records the sign of each operand and latches the absolute values.
  - The counter is cleared to 0.
- RUN performs one iteration per edge, on edges k+1 .. k+32, then goes to FIX.
  - Multiply: shift-add; one multiplier bit per cycle into a 2*WIDTH accumulator.
  - Divide: restoring; one quotient bit per cycle; remainder register is WIDTH+1 bits.
- FIX, at edge k+33: applies sign correction, writes HI/LO, returns to IDLE.
- busy = 1 from after edge k through edge k+33 (33 cycles). It is registered and derived from state != IDLE.
- done = 1 for exactly the one cycle following edge k+33.
- Result latency: new hi/lo are visible 34 cycles after the start edge.
- Multiply result: {hi, lo} = full 2*WIDTH product.
  - Signed product is negated in two's complement when the operand signs differ.
- Divide result: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; it is negated when the signs differ.
  - Signed remainder takes the sign of the dividend.
- Divide by zero (b = 0, signed or unsigned): lo = 32'hFFFFFFFF, hi = a as latched (raw, no sign fix).
- Signed 32'h80000000 / -1: lo = 32'h80000000, hi = 0. No trap.
- start while busy is ignored; operands and op in flight are unchanged.
- mthi/mtlo while IDLE and start = 0: the selected register takes wdata on the next edge. Both may be asserted together.
- mthi/mtlo while busy are ignored; the control unit must stall them.
- start together with mthi/mtlo in IDLE: start wins and the mt write is dropped.
- hi/lo hold their values during RUN; they change only at FIX, on mt writes, or at reset.

Decomposition:
- Shared package holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - FSM state encoding;
  - DIV0_QUOT constant (all ones).
- One sub-module is natural: muldiv_core. It holds the iterative datapath (accumulator/remainder, shift, one iteration step).
- muldiv_unit itself holds the FSM, sign handling, HI/LO registers and handshake.

Test Plan:
- Reset then idle: after reset_n is released, hi = lo = 0, busy = done = 0. Assert reset_n = 0 at cycle 10 of a DIV -> hi = lo = 0, busy = 0 immediately; no done pulse afterwards.
- MULTU a = FFFFFFFF, b = FFFFFFFF -> busy high for 33 cycles, done pulse, then hi = FFFFFFFE, lo = 00000001. MULT a = FFFFFFFD (-3), b = 5 -> hi = FFFFFFFF, lo = FFFFFFF1.
- DIV a = FFFFFFF9 (-7), b = 2 -> lo = FFFFFFFD, hi = FFFFFFFF. DIVU a = 7, b = 2 -> lo = 3, hi = 1. DIV a = 80000000, b = FFFFFFFF -> lo = 80000000, hi = 0.
- DIVU a = 12345678, b = 0 -> lo = FFFFFFFF, hi = 12345678. DIV a = 80000001, b = 0 -> lo = FFFFFFFF, hi = 80000001.
- Second start pulse with new operands mid-RUN -> ignored; the first op's result is produced at the original cycle. mthi wdata = AAAA5555 during busy -> hi unchanged.
- Idle mthi = mtlo = 1, wdata = 0000BEEF -> hi = lo = 0000BEEF next cycle. start + mtlo same cycle -> op runs, lo is not written by mtlo.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   op encodings  : OP_MULT, OP_MULTU, OP_DIV, OP_DIVU (2 bits)
//   state_t       : IDLE -> RUN (WIDTH iterations) -> FIX (sign fix + HI/LO write)
//   DIV0_QUOT     : quotient written on divide by zero (all ones, slice to WIDTH)
package muldiv_unit_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/muldiv_unit_core.sv
// Iterative unsigned datapath: shift-add multiply / restoring divide.
//   load      : latch magnitudes (mcand/dividend = a_abs, mplr/divisor = b_abs) and mode
//   step      : perform one iteration (one multiplier bit or one quotient bit)
//   prod      : 2*WIDTH product after WIDTH steps
//   quot, rem : quotient / remainder after WIDTH steps
module muldiv_unit_core #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic               load_div,
    input  logic               step,
    input  logic [WIDTH-1:0]   a_abs,
    input  logic [WIDTH-1:0]   b_abs,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem
);

    // acc low half holds the multiplier (mul) or dividend shifting into quotient (div);
    // acc high half is the running partial product for multiply.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor
    logic [WIDTH:0]     rem_q;     // partial remainder
    logic               div_mode;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   shifted;
    logic [WIDTH+1:0]   diff;

    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
        shifted = {rem_q, acc[WIDTH-1]};
        diff    = shifted - {2'b00, opnd};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            opnd     <= '0;
            rem_q    <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            div_mode <= load_div;
            opnd     <= load_div ? b_abs : a_abs;
            acc      <= {{WIDTH{1'b0}}, (load_div ? a_abs : b_abs)};
            rem_q    <= '0;
        end else if (step) begin
            if (div_mode) begin
                // diff sign bit set means the trial subtract failed: restore
                if (diff[WIDTH+1]) rem_q <= shifted[WIDTH:0];
                else               rem_q <= diff[WIDTH:0];
                acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH+1]};
            end else begin
                acc <= {mul_sum, acc[WIDTH-1:1]};
            end
        end
    end

    assign prod = acc;
    assign quot = acc[WIDTH-1:0];
    assign rem  = rem_q[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   a, b, op, start : operands and launch (start sampled only when idle)
//   mthi, mtlo      : idle writes of wdata into HI / LO (start has priority)
//   hi, lo          : HI/LO registers
//   busy            : op in flight (RUN or FIX), registered
//   done            : one-cycle pulse after HI/LO are written by an op
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             start,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div, is_signed, sign_a, sign_b, b_zero;
    logic [WIDTH-1:0] a_raw;

    logic             op_signed, launch;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quot, rem, res_hi, res_lo;

    assign op_signed = ~op[0];
    assign launch    = (state == ST_IDLE) && start;
    assign a_abs     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_abs     = (op_signed && b[WIDTH-1]) ? -b : b;

    muldiv_unit_core #(.WIDTH(WIDTH)) u_core (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (launch),
        .load_div (op[1]),
        .step     (state == ST_RUN),
        .a_abs    (a_abs),
        .b_abs    (b_abs),
        .prod     (prod),
        .quot     (quot),
        .rem      (rem)
    );

    // Sign correction applied in FIX. Magnitude of 0x80000000 is itself as unsigned,
    // so MIN / -1 falls out as quotient 0x80000000, remainder 0 with no special case.
    always_comb begin
        prod_fix = (is_signed && (sign_a ^ sign_b)) ? -prod : prod;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                res_lo = DIV0_QUOT[WIDTH-1:0];
                res_hi = a_raw;
            end else begin
                res_lo = (is_signed && (sign_a ^ sign_b)) ? -quot : quot;
                res_hi = (is_signed && sign_a) ? -rem : rem;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            b_zero    <= 1'b0;
            a_raw     <= '0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        is_div    <= op[1];
                        is_signed <= op_signed;
                        sign_a    <= op_signed & a[WIDTH-1];
                        sign_b    <= op_signed & b[WIDTH-1];
                        b_zero    <= (b == '0);
                        a_raw     <= a;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {hi,lo} from a plain
// arithmetic model; a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic [1:0]  op = '0;
    logic        start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    logic [63:0] expq[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .a(a), .b(b), .op(op), .start(start),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hi(hi), .lo(lo),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: {hi, lo} from 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (o)
            2'b00: return sx * sy;
            2'b01: return ux * uy;
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (o == 2'b10) begin q = sx / sy; r = sx % sy; end
                else begin q = longint'(ux / uy); r = longint'(ux % uy); end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && done) begin
            if (expq.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else chk("result", {hi, lo}, expq.pop_front());
        end
    end

    // inject: 0 none, 1 second start mid-RUN, 2 mthi mid-RUN, 3 mtlo with start
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int inject);
        logic [31:0] h0, l0;
        int n;
        bit hold;
        @(negedge clock);
        h0 = hi; l0 = lo;
        op = o; a = x; b = y; start = 1'b1;
        if (inject == 3) begin mtlo = 1'b1; wdata = 32'h0000_1234; end
        expq.push_back(model(o, x, y));
        @(posedge clock);
        #1 start = 1'b0; mtlo = 1'b0;
        n = 0; hold = 1'b1;
        @(negedge clock);
        while (busy && n < 60) begin
            if (hi !== h0 || lo !== l0) hold = 1'b0;
            n++;
            if (inject == 1 && n == 5) begin
                start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
            end else if (inject == 2 && n == 7) begin
                mthi = 1'b1; wdata = 32'hAAAA_5555;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0; mthi = 1'b0;
        chk("busy_cycles", 64'(n), 64'd33);
        chk("hilo_hold", {63'd0, hold}, 64'd1);
        chk("done_pulse", {63'd0, done}, 64'd1);
        @(negedge clock);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int ds;
        logic [31:0] ra, rb;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);

        // idle MTHI + MTLO together
        @(negedge clock);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_BEEF;
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both", {hi, lo}, 64'h0000_BEEF_0000_BEEF);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'd7, 32'd2, 0);
        chk("divu_small", {hi, lo}, 64'h0000_0001_0000_0003);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_min_neg1", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(2'b11, 32'h1234_5678, 32'd0, 0);
        chk("divu_by0", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
        run_op(2'b10, 32'h8000_0001, 32'd0, 0);
        chk("div_by0", {hi, lo}, 64'h8000_0001_FFFF_FFFF);

        run_op(2'b00, 32'd1000, 32'hFFFF_FFFE, 1);   // second start ignored
        chk("restart_ignored", {hi, lo}, 64'hFFFF_FFFF_FFFF_F830);
        run_op(2'b11, 32'd100, 32'd7, 2);            // mthi during busy ignored
        run_op(2'b01, 32'd3, 32'd4, 3);              // start beats mtlo
        chk("start_beats_mtlo", {hi, lo}, 64'd12);

        repeat (30) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(2'($urandom), ra, rb, 0);
        end

        // reset in the middle of a DIV
        @(negedge clock);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_0001;
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b0;
        op = 2'b10; a = 32'd100; b = 32'd3; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        ds = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) ds++;
        end
        chk("abort_no_done", 64'(ds), 64'd0);
        chk("abort_hilo_after", {hi, lo}, 64'd0);
        chk("queue_drained", 64'(expq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
